// File: rtl/cvp14_pkg.sv
// Shared definitions for the vector load/store sequencer: datapath widths,
// opcode constants and the sequencer state encoding.
package cvp14_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int VREG_IDX_W = 3;
  localparam int ELEM_IDX_W = 4;
  localparam int OFFSET_W   = 6;
  localparam int STRIDE_W   = 4;

  // Instruction opcodes decoded by the top-level controller.
  localparam logic [3:0] OPC_VLD = 4'b0100;
  localparam logic [3:0] OPC_VST = 4'b0101;

  typedef enum logic [2:0] {
    VLS_IDLE    = 3'd0,
    VLS_LD_REQ  = 3'd1,
    VLS_LD_WAIT = 3'd2,
    VLS_LD_WB   = 3'd3,
    VLS_ST_RD   = 3'd4,
    VLS_ST_WR   = 3'd5,
    VLS_FIN     = 3'd6
  } vls_state_e;

  // The offset field is unsigned and zero-extended to the address width.
  function automatic logic [ADDR_W-1:0] ext_offset(input logic [OFFSET_W-1:0] off);
    return {{(ADDR_W-OFFSET_W){1'b0}}, off};
  endfunction

endpackage

// File: rtl/vls_sequencer_addr_gen.sv
// vls_addr_gen: element address generator for the vector load/store sequencer.
// Holds base+offset, the element counter and the stride. The address is kept
// as a running sum (base+offset, then +stride per element), which equals
// Base + Offset + i*Stride modulo 2^16 without a multiplier.
module vls_addr_gen
  import cvp14_pkg::*;
#(
  parameter int NUM_ELEM = 16
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  i_load,
  input  logic                  i_inc,
  input  logic [ADDR_W-1:0]     i_base,
  input  logic [OFFSET_W-1:0]   i_offset,
  input  logic [STRIDE_W-1:0]   i_stride,
  output logic [ADDR_W-1:0]     o_addr,
  output logic [ELEM_IDX_W-1:0] o_idx,
  output logic                  o_last
);

  localparam logic [ELEM_IDX_W-1:0] LAST_IDX = ELEM_IDX_W'(NUM_ELEM - 1);

  logic [ADDR_W-1:0]     r_addr;
  logic [ELEM_IDX_W-1:0] r_idx;
  logic [STRIDE_W-1:0]   r_stride;
  logic [ADDR_W-1:0]     w_stride_ext;

  assign w_stride_ext = {{(ADDR_W-STRIDE_W){1'b0}}, r_stride};

  // Load operands at Start, then step address and element index together.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_addr   <= '0;
      r_idx    <= '0;
      r_stride <= '0;
    end else if (i_load) begin
      r_addr   <= i_base + ext_offset(i_offset);
      r_idx    <= '0;
      r_stride <= i_stride;
    end else if (i_inc) begin
      r_addr   <= r_addr + w_stride_ext;
      r_idx    <= r_idx + 1'b1;
    end
  end

  assign o_addr = r_addr;
  assign o_idx  = r_idx;
  assign o_last = (r_idx == LAST_IDX);

endmodule

// File: rtl/vls_sequencer.sv
// vls_sequencer: walks NUM_ELEM 16-bit elements between system memory and the
// vector register file serial port (vld: memory -> vreg, vst: vreg -> memory).
// Optional build macro VLS_STRIDE_EN adds a 4-bit Stride input latched at
// Start; without it the element stride is fixed at 1.
// Output strobes are registered from the next state, so each strobe is high
// during exactly the cycle the FSM spends in the state that owns it.
module vls_sequencer
  import cvp14_pkg::*;
#(
  parameter int NUM_ELEM = 16,
  parameter int RD_LAT   = 1
) (
  input  logic                  Clk1,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Op,
  input  logic [VREG_IDX_W-1:0] VSel,
  input  logic [ADDR_W-1:0]     Base,
  input  logic [OFFSET_W-1:0]   Offset,
`ifdef VLS_STRIDE_EN
  input  logic [STRIDE_W-1:0]   Stride,
`endif
  output logic                  Busy,
  output logic                  Done,
  output logic [ADDR_W-1:0]     Addr,
  output logic                  RD,
  output logic                  WR,
  output logic [DATA_W-1:0]     DataOut,
  input  logic [DATA_W-1:0]     DataIn,
  output logic [VREG_IDX_W-1:0] vAddr,
  output logic [ELEM_IDX_W-1:0] vElem,
  output logic                  vWR_s,
  output logic                  vRD_s,
  output logic [DATA_W-1:0]     vInS,
  input  logic [DATA_W-1:0]     vOutS
);

  localparam int              WAIT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);

  vls_state_e            r_state;
  vls_state_e            w_state_next;
  logic [WAIT_W-1:0]     r_wait;
  logic [WAIT_W-1:0]     w_wait_next;

  logic                  w_load;
  logic                  w_inc;
  logic                  w_capture;
  logic                  w_last;
  logic [STRIDE_W-1:0]   w_stride;
  logic [ADDR_W-1:0]     w_addr;
  logic [ELEM_IDX_W-1:0] w_idx;

  logic                  r_busy;
  logic                  r_done;
  logic                  r_rd;
  logic                  r_wr;
  logic                  r_vwr;
  logic                  r_vrd;
  logic [DATA_W-1:0]     r_vins;
  logic [VREG_IDX_W-1:0] r_vaddr;

`ifdef VLS_STRIDE_EN
  assign w_stride = Stride;
`else
  assign w_stride = STRIDE_W'(1);
`endif

  vls_addr_gen #(
    .NUM_ELEM (NUM_ELEM)
  ) u_addr_gen (
    .clk      (Clk1),
    .srst     (Reset),
    .i_load   (w_load),
    .i_inc    (w_inc),
    .i_base   (Base),
    .i_offset (Offset),
    .i_stride (w_stride),
    .o_addr   (w_addr),
    .o_idx    (w_idx),
    .o_last   (w_last)
  );

  // State and read-latency wait counter.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      r_state <= VLS_IDLE;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
    end
  end

  // Next-state logic plus the one-cycle control pulses for the address
  // generator and the DataIn capture.
  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait;
    w_load       = 1'b0;
    w_inc        = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      VLS_IDLE: begin
        if (Start) begin
          w_load       = 1'b1;
          w_state_next = Op ? VLS_ST_RD : VLS_LD_REQ;
        end
      end
      VLS_LD_REQ: begin
        w_wait_next  = '0;
        w_state_next = VLS_LD_WAIT;
      end
      VLS_LD_WAIT: begin
        if (r_wait == WAIT_LAST) begin
          w_capture    = 1'b1;
          w_state_next = VLS_LD_WB;
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end
      VLS_LD_WB: begin
        if (w_last) begin
          w_state_next = VLS_FIN;
        end else begin
          w_inc        = 1'b1;
          w_state_next = VLS_LD_REQ;
        end
      end
      VLS_ST_RD: begin
        w_state_next = VLS_ST_WR;
      end
      VLS_ST_WR: begin
        if (w_last) begin
          w_state_next = VLS_FIN;
        end else begin
          w_inc        = 1'b1;
          w_state_next = VLS_ST_RD;
        end
      end
      VLS_FIN: begin
        w_state_next = VLS_IDLE;
      end
      default: begin
        w_state_next = VLS_IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_vwr   <= 1'b0;
      r_vrd   <= 1'b0;
      r_vins  <= '0;
      r_vaddr <= '0;
    end else begin
      r_busy <= (w_state_next != VLS_IDLE);
      r_done <= (w_state_next == VLS_FIN);
      r_rd   <= (w_state_next == VLS_LD_REQ);
      r_wr   <= (w_state_next == VLS_ST_WR);
      r_vwr  <= (w_state_next == VLS_LD_WB);
      r_vrd  <= (w_state_next == VLS_ST_RD);
      if (w_load) begin
        r_vaddr <= VSel;
      end
      if (w_capture) begin
        r_vins <= DataIn;
      end
    end
  end

  assign Busy  = r_busy;
  assign Done  = r_done;
  assign RD    = r_rd;
  assign WR    = r_wr;
  assign vWR_s = r_vwr;
  assign vRD_s = r_vrd;
  assign vInS  = r_vins;
  assign vAddr = r_vaddr;
  assign Addr  = w_addr;
  assign vElem = w_idx;

  // vOutS only becomes valid in the cycle after vRD_s, which is the ST_WR
  // cycle itself, so the write data is forwarded from the register file's
  // output register and gated by the registered WR strobe (0 otherwise).
  assign DataOut = r_wr ? vOutS : '0;

endmodule

// File: tb/tb_vls_sequencer.sv
// Self-checking bench for vls_sequencer. Stimulus pushes the expected memory
// and vector-port events of each transfer into queues; a negedge monitor pops
// and compares whenever the DUT raises a strobe or Done.
// Build with +define+VLS_STRIDE_EN to exercise the Stride port.
`timescale 1ns/1ps
module tb_vls_sequencer;

  localparam int NUM_ELEM = 16;
  localparam int RD_LAT   = 1;
  localparam int LAT_VLD  = NUM_ELEM * (RD_LAT + 2) + 1;
  localparam int LAT_VST  = NUM_ELEM * 2 + 1;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Op;
  logic [2:0]  VSel;
  logic [15:0] Base;
  logic [5:0]  Offset;
`ifdef VLS_STRIDE_EN
  logic [3:0]  Stride;
`endif
  logic        Busy, Done, RD, WR, vWR_s, vRD_s;
  logic [15:0] Addr, DataOut, vInS;
  logic [2:0]  vAddr;
  logic [3:0]  vElem;
  logic [15:0] DataIn = '0;
  logic [15:0] vOutS  = '0;

  always #5 clk = ~clk;

  vls_sequencer #(.NUM_ELEM(NUM_ELEM), .RD_LAT(RD_LAT)) dut (
    .Clk1    (clk),
    .Reset   (Reset),
    .Start   (Start),
    .Op      (Op),
    .VSel    (VSel),
    .Base    (Base),
    .Offset  (Offset),
`ifdef VLS_STRIDE_EN
    .Stride  (Stride),
`endif
    .Busy    (Busy),
    .Done    (Done),
    .Addr    (Addr),
    .RD      (RD),
    .WR      (WR),
    .DataOut (DataOut),
    .DataIn  (DataIn),
    .vAddr   (vAddr),
    .vElem   (vElem),
    .vWR_s   (vWR_s),
    .vRD_s   (vRD_s),
    .vInS    (vInS),
    .vOutS   (vOutS)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int wr_cnt   = 0;
  int mon_ns;
  int mon_st;
  bit prev_busy = 1'b0;
  bit prev_done = 1'b0;

  logic [15:0] rd_q[$];
  logic [22:0] wb_q[$];
  logic [6:0]  vrd_q[$];
  logic [31:0] wr_q[$];
  int          lat_q[$];
  int          start_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: DUT event with no expected entry (Addr=0x%0h vElem=%0d)", name, Addr, vElem);
  endfunction

  // Memory and vector register file contents.
  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] vreg_val(input logic [2:0] v, input int k);
    return 16'h1000 + 16'(k) + {5'b0, v ^ 3'd5, 8'h00};
  endfunction

  // Environment: one-cycle-latency memory and vector register file read port.
  always @(posedge clk) begin
    if (RD)    DataIn <= mem_val(Addr);
    if (vRD_s) vOutS  <= vreg_val(vAddr, int'(vElem));
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every DUT event against the scoreboard queues.
  always @(negedge clk) begin
    if (Reset) begin
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      mon_ns = int'(RD) + int'(WR) + int'(vWR_s) + int'(vRD_s);
      if (mon_ns != 0) chk("strobe_exclusive", mon_ns, 1);
      if (RD) begin
        if (rd_q.size() == 0) unexpected("rd_unexpected");
        else chk("rd_addr", Addr, rd_q.pop_front());
      end
      if (vWR_s) begin
        if (wb_q.size() == 0) unexpected("vwr_unexpected");
        else chk("vwr_vaddr_velem_vins", {vAddr, vElem, vInS}, wb_q.pop_front());
      end
      if (vRD_s) begin
        if (vrd_q.size() == 0) unexpected("vrd_unexpected");
        else chk("vrd_vaddr_velem", {vAddr, vElem}, vrd_q.pop_front());
      end
      if (WR) begin
        wr_cnt++;
        if (wr_q.size() == 0) unexpected("wr_unexpected");
        else chk("wr_addr_data", {Addr, DataOut}, wr_q.pop_front());
      end
      if (Done) begin
        done_cnt++;
        chk("busy_during_done", Busy, 1);
        if (lat_q.size() == 0) unexpected("done_unexpected");
        else begin
          mon_st = start_q.pop_front();
          // Start sampled at edge 0; Done is seen by the controller at edge cyc-st+1.
          chk("done_latency", cyc - mon_st + 1, lat_q.pop_front());
        end
      end
      if (prev_busy && !Busy) chk("busy_falls_with_done", prev_done, 1);
      prev_busy = Busy;
      prev_done = Done;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_expect(input bit op, input logic [2:0] vs, input logic [15:0] b,
                             input logic [5:0] off, input logic [3:0] str);
    logic [15:0] a;
    for (int k = 0; k < NUM_ELEM; k++) begin
      a = b + 16'(off) + 16'(k * int'(str));
      if (!op) begin
        rd_q.push_back(a);
        wb_q.push_back({vs, 4'(k), mem_val(a)});
      end else begin
        vrd_q.push_back({vs, 4'(k)});
        wr_q.push_back({a, vreg_val(vs, k)});
      end
    end
    lat_q.push_back(op ? LAT_VST : LAT_VLD);
    start_q.push_back(cyc + 1);
  endtask

  task automatic drive(input bit op, input logic [2:0] vs, input logic [15:0] b, input logic [5:0] off);
    Start  = 1'b1;
    Op     = op;
    VSel   = vs;
    Base   = b;
    Offset = off;
  endtask

  // str must be 1 unless the Stride port exists.
  task automatic issue(input bit op, input logic [2:0] vs, input logic [15:0] b,
                       input logic [5:0] off, input logic [3:0] str);
    push_expect(op, vs, b, off, str);
`ifdef VLS_STRIDE_EN
    Stride = str;
`endif
    drive(op, vs, b, off);
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    int t  = 0;
    while (done_cnt == d0 && t < 200) begin
      tick();
      t++;
    end
    if (done_cnt == d0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: no Done within 200 cycles", name);
    end
    chk({name, "_drained"}, rd_q.size() + wb_q.size() + vrd_q.size() + wr_q.size(), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d0, t, w0;
    bit          rop;
    logic [3:0]  rstr;
    Reset = 1'b1; Start = 1'b0; Op = 1'b0; VSel = '0; Base = '0; Offset = '0;
`ifdef VLS_STRIDE_EN
    Stride = 4'd1;
`endif
    repeat (3) tick();
    chk("rst_Busy", Busy, 0);   chk("rst_Done", Done, 0);
    chk("rst_RD", RD, 0);       chk("rst_WR", WR, 0);
    chk("rst_vWR_s", vWR_s, 0); chk("rst_vRD_s", vRD_s, 0);
    chk("rst_Addr", Addr, 0);   chk("rst_DataOut", DataOut, 0);
    chk("rst_vInS", vInS, 0);   chk("rst_vAddr", vAddr, 0);
    chk("rst_vElem", vElem, 0);
    Reset = 1'b0;
    tick();

    // Directed vld, vst and address wrap.
    issue(1'b0, 3'd3, 16'h0100, 6'd4, 4'd1);
    wait_done("vld_basic");
    issue(1'b1, 3'd5, 16'h2000, 6'd0, 4'd1);
    wait_done("vst_basic");
    issue(1'b1, 3'd2, 16'hFFF8, 6'h3F, 4'd1);
    wait_done("vst_wrap");

    // Start held every cycle during a vld with changing operands.
    d0 = done_cnt;
    push_expect(1'b0, 3'd6, 16'h4000, 6'd9, 4'd1);
`ifdef VLS_STRIDE_EN
    Stride = 4'd1;
`endif
    drive(1'b0, 3'd6, 16'h4000, 6'd9);
    t = 0;
    while (done_cnt == d0 && t < 200) begin
      tick();
      t++;
      if (done_cnt == d0) begin
        drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom), 6'($urandom));
`ifdef VLS_STRIDE_EN
        Stride = 4'($urandom);
`endif
      end
    end
    Start = 1'b0;
    if (done_cnt == d0) begin
      n_checks++; n_errors++;
      $display("FAIL start_spam_timeout: no Done within 200 cycles");
    end
    repeat (5) tick();
    chk("start_spam_single_done", done_cnt - d0, 1);
    chk("start_spam_idle_after", Busy, 0);

    // Reset during element 7 of a vst, then a normal transfer.
    issue(1'b1, 3'd5, 16'h3000, 6'd2, 4'd1);
    w0 = wr_cnt; t = 0;
    while (wr_cnt - w0 < 7 && t < 100) begin
      tick();
      t++;
    end
    chk("abort_reached_elem7", wr_cnt - w0, 7);
    Reset = 1'b1;
    rd_q.delete(); wb_q.delete(); vrd_q.delete(); wr_q.delete(); lat_q.delete(); start_q.delete();
    tick();
    chk("abort_Busy", Busy, 0);
    chk("abort_WR", WR, 0);
    chk("abort_Done", Done, 0);
    chk("abort_vRD_s", vRD_s, 0);
    Reset = 1'b0;
    repeat (4) tick();
    issue(1'b1, 3'd1, 16'h5555, 6'd17, 4'd1);
    wait_done("after_abort");

`ifdef VLS_STRIDE_EN
    issue(1'b0, 3'd0, 16'h0010, 6'd0, 4'd3);
    wait_done("stride3");
    issue(1'b0, 3'd4, 16'h0010, 6'd0, 4'd0);
    wait_done("stride0");
`endif

    // Randomized transfers, issued back to back.
    for (int n = 0; n < 8; n++) begin
      rop = 1'($urandom_range(0, 1));
`ifdef VLS_STRIDE_EN
      rstr = 4'($urandom);
`else
      rstr = 4'd1;
`endif
      issue(rop, 3'($urandom_range(0, 7)), 16'($urandom), 6'($urandom), rstr);
      wait_done(rop ? "rand_vst" : "rand_vld");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vls_sequencer.md
Name: vls_sequencer

Overview:
Sequencer for vector load (vld) and vector store (vst) transfers between system memory and the vector register file serial port.
- The top-level controller issues one Start with operands, then waits for Done.
- The block walks NUM_ELEM 16-bit elements and generates all memory and vector-register strobes.
- It owns the memory port for the whole transfer; the controller holds off instruction fetch while Busy is high.

Parameters:
NUM_ELEM, 16, elements per vector (power of two, 2..16)
RD_LAT, 1, cycles from RD high to DataIn valid (>=1)

Ports:
Clk1  in  1  single clock; all logic on posedge
Reset  in  1  synchronous reset, active-high
Start  in  1  begin transfer; sampled only in IDLE
Op  in  1  0 = vld (memory -> vreg), 1 = vst (vreg -> memory)
VSel  in  3  destination/source vector register index
Base  in  16  base address (scalar register contents)
Offset  in  6  unsigned offset, zero-extended
Busy  out  1  high in every state except IDLE
Done  out  1  one-cycle completion pulse
Addr  out  16  memory address
RD  out  1  memory read strobe
WR  out  1  memory write strobe
DataOut  out  16  memory write data
DataIn  in  16  memory read data
vAddr  out  3  vector register index
vElem  out  4  element index within the vector
vWR_s  out  1  vector serial-port element write
vRD_s  out  1  vector serial-port element read
vInS  out  16  element write data to the vector register file
vOutS  in  16  element read data; valid the cycle after vRD_s

Behaviour:
- Outputs: all outputs are registered.
- Reset: at the Reset edge, state goes to IDLE and the element counter i goes to 0.
  - Busy, Done, RD, WR, vWR_s and vRD_s go to 0.
  - Addr, DataOut, vInS, vAddr and vElem go to 0.
- Reset mid-transfer: abort; no Done pulse is generated; memory writes already issued are not undone.
- Start acceptance: Start in IDLE latches Op, VSel, Base, Offset and sets i=0. Busy is high from the next cycle.
- Start while Busy: ignored; latched operands are unchanged.
- Address: element address = Base + Offset + i, computed modulo 2^16 (wraps 0xFFFF -> 0x0000 silently).
- States: IDLE, LD_REQ, LD_WAIT, LD_WB, ST_RD, ST_WR, FIN.
- IDLE: on Start, go to LD_REQ if Op=0, or ST_RD if Op=1.
- LD_REQ (1 cycle): Addr = element address, RD=1. Go to LD_WAIT.
- LD_WAIT (RD_LAT cycles, wait counter): RD=0. On the final wait cycle, capture DataIn into vInS. Go to LD_WB.
- LD_WB (1 cycle): vAddr=VSel, vElem=i, vWR_s=1. If i==NUM_ELEM-1, go to FIN; else i++ and go to LD_REQ.
- ST_RD (1 cycle): vAddr=VSel, vElem=i, vRD_s=1. Go to ST_WR.
- ST_WR (1 cycle): Addr = element address, DataOut = vOutS, WR=1, vRD_s=0. If last element, go to FIN; else i++ and go to ST_RD.
- FIN (1 cycle): Done=1, all strobes 0. Go to IDLE. Busy falls with Done.
- Strobe rule: RD, WR, vWR_s and vRD_s are each high for exactly one cycle per element; no two are ever high in the same cycle.
- Latency (Start edge to Done high):
  - vld: NUM_ELEM*(RD_LAT+2)+1 cycles (49 at defaults).
  - vst: NUM_ELEM*2+1 cycles (33 at defaults).
- Back-to-back: Start in the IDLE cycle right after FIN is accepted.

Optional Feature:
VLS_STRIDE_EN
- Defined: adds input port Stride (4-bit unsigned), latched at Start. Element address = Base + Offset + i*Stride, modulo 2^16. Stride=0 makes every element use the same address (legal).
- Undefined: no Stride port; stride is fixed at 1.

Decomposition:
- Shared package cvp14_pkg: opcode constants (vld=4'b0100, vst=4'b0101), the vls state enum, and widths (DATA_W=16, ADDR_W=16, VREG_IDX_W=3).
- Sub-module vls_addr_gen: holds the latched base+offset, the element counter and the optional stride multiply, and outputs the registered element address.

Test Plan:
- vld: Base=0x0100, Offset=4, VSel=3; memory model returns mem[a]=a^0x5A5A → 16 vWR_s pulses, vElem 0..15, vInS=0x0104^0x5A5A .. 0x0113^0x5A5A; Done at cycle 49 after Start.
- vst: VSel=5, vreg model element k=0x1000+k; Base=0x2000, Offset=0 → WR at Addr 0x2000..0x200F with DataOut 0x1000..0x100F; Done at cycle 33.
- Wrap: vst with Base=0xFFF8, Offset=0x3F → element addresses 0x0037..0x0046, all mod 2^16; no X on Addr.
- Start pulsed every cycle during a vld → exactly one transfer and one Done; operands unchanged; Busy never drops early.
- Reset at element 7 of a vst → next cycle state IDLE, WR=0, no Done; a new Start then completes normally.
- VLS_STRIDE_EN defined, vld with Stride=3, Base=0x0010, Offset=0 → RD addresses 0x0010, 0x0013, ..., 0x003D; Stride=0 → all 16 reads at 0x0010.
